jam_cost_scheduler: RTL and testbench



---
 rtl/jam_cost_scheduler_pkg.sv | 14 +
 rtl/jam_cost_scheduler_if.sv | 10 +
 rtl/jam_cost_scheduler_min_tracker.sv | 28 ++
 rtl/jam_cost_scheduler.sv | 81 ++++++++
 tb/tb_jam_cost_scheduler.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/jam_cost_scheduler_pkg.sv
// jam_pkg: shared widths, state encoding and perm slicing for the cost scheduler
package jam_pkg;
    localparam int N_WORK = 8;
    localparam int COST_W = 7;
    localparam int SUM_W = 10;
    localparam int CNT_W = 4;
    localparam int PERM_W = N_WORK * 3;
    localparam logic [SUM_W-1:0] MIN_INIT = 10'd1023;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;
    typedef enum logic [2:0] {IDLE, WAIT, FETCH, CMP, DONE} state_t;
    function automatic logic [2:0] perm_job(input logic [PERM_W-1:0] p, input logic [2:0] k);
        return p[k*3 +: 3];
    endfunction
endpackage

// File: rtl/jam_cost_scheduler_if.sv
// jam_cost_scheduler_if: valid/ready permutation handshake from the generator
interface jam_cost_scheduler_if;
    import jam_pkg::*;
    logic              perm_valid;
    logic              perm_ready;
    logic              perm_last;
    logic [PERM_W-1:0] perm;
    modport master(output perm_valid, perm, perm_last, input perm_ready);
    modport slave(input perm_valid, perm, perm_last, output perm_ready);
endinterface

// File: rtl/jam_cost_scheduler_min_tracker.sv
// jam_min_tracker: running minimum cost and saturating count of permutations tying it
module jam_min_tracker
    import jam_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             cmp,
    input  logic             pruned,
    input  logic [SUM_W-1:0] sum,
    output logic [SUM_W-1:0] min_cost,
    output logic [CNT_W-1:0] match_count
);
    // fold each completed, unpruned permutation into the minimum and its tie count
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            min_cost <= MIN_INIT;
            match_count <= '0;
        end else if (cmp && !pruned) begin
            if (sum < min_cost) begin
                min_cost <= sum;
                match_count <= CNT_W'(1);
            end else if (sum == min_cost && match_count != CNT_MAX) begin
                match_count <= match_count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/jam_cost_scheduler.sv
// jam_cost_scheduler: walks each permutation through the cost table and tracks the minimum
module jam_cost_scheduler
    import jam_pkg::*;
#(
    parameter bit PRUNE = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    jam_cost_scheduler_if.slave   pif,
    output logic [2:0]            W,
    output logic [2:0]            J,
    input  logic [COST_W-1:0]     Cost,
    output logic [CNT_W-1:0]      MatchCount,
    output logic [SUM_W-1:0]      MinCost,
    output logic                  Valid
);
    state_t            state, state_nx;
    logic [PERM_W-1:0] pbuf;
    logic [2:0]        k;
    logic [SUM_W-1:0]  sum, sum_nx;
    logic              last_f, pruned, prune_hit;

    // k only advances while another lookup follows, so W/J naturally hold their last values
    assign W = k;
    assign J = perm_job(pbuf, k);
    assign pif.perm_ready = state == WAIT;
    assign Valid = state == DONE;

    // next state; a lookup that pushes the partial sum past the minimum ends the walk early
    always_comb begin
        state_nx = state;
        sum_nx = sum + SUM_W'(Cost);
        prune_hit = PRUNE && (sum_nx > MinCost);
        case (state)
            IDLE:    if (start) state_nx = WAIT;
            WAIT:    if (pif.perm_valid) state_nx = FETCH;
            FETCH:   if (k == 3'(N_WORK - 1) || prune_hit) state_nx = CMP;
            CMP:     state_nx = last_f ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else state <= state_nx;
    end

    // permutation buffer, lookup index and running sum
    always_ff @(posedge CLK) begin
        if (RST) begin
            pbuf <= '0;
            k <= '0;
            sum <= '0;
            last_f <= 1'b0;
            pruned <= 1'b0;
        end else if (state == WAIT && pif.perm_valid) begin
            pbuf <= pif.perm;
            last_f <= pif.perm_last;
            sum <= '0;
            k <= '0;
            pruned <= 1'b0;
        end else if (state == FETCH) begin
            sum <= sum_nx;
            pruned <= prune_hit;
            if (state_nx == FETCH) k <= k + 1'b1;
        end
    end

    jam_min_tracker u_min (
        .clk        (CLK),
        .rst        (RST),
        .clear      (state == IDLE && start),
        .cmp        (state == CMP),
        .pruned     (pruned),
        .sum        (sum),
        .min_cost   (MinCost),
        .match_count(MatchCount)
    );
endmodule

// File: tb/tb_jam_cost_scheduler.sv
// tb_jam_cost_scheduler: directed checks of lookup order, min/tie tracking, pruning and reset
module tb_jam_cost_scheduler;
    localparam logic [23:0] ID  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [23:0] REV = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam logic [23:0] MIX = {3'd2, 3'd5, 3'd0, 3'd7, 3'd1, 3'd4, 3'd6, 3'd3};
    localparam logic [23:0] SW  = {3'd0, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd7};
    localparam logic [23:0] BAD = {8{3'd7}};

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [23:0] perm_d = '0;
    logic        last_d = 1'b0, valid_d = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [2:0]  w0, j0, w1, j1;
    logic [6:0]  cost0, cost1;
    logic [3:0]  mc0, mc1;
    logic [9:0]  min0, min1;
    logic        v0, v1;
    int          n_chk = 0, n_pass = 0;

    jam_cost_scheduler_if if0();
    jam_cost_scheduler_if if1();
    assign if0.perm = perm_d;
    assign if0.perm_last = last_d;
    assign if0.perm_valid = valid_d;
    assign if1.perm = perm_d;
    assign if1.perm_last = last_d;
    assign if1.perm_valid = valid_d;

    jam_cost_scheduler #(.PRUNE(1'b1)) dut0 (
        .CLK(CLK), .RST(RST), .start(start0), .pif(if0), .W(w0), .J(j0),
        .Cost(cost0), .MatchCount(mc0), .MinCost(min0), .Valid(v0)
    );
    jam_cost_scheduler #(.PRUNE(1'b0)) dut1 (
        .CLK(CLK), .RST(RST), .start(start1), .pif(if1), .W(w1), .J(j1),
        .Cost(cost1), .MatchCount(mc1), .MinCost(min1), .Valid(v1)
    );

    always #5 CLK = ~CLK;

    // mode 0: flat 5; mode 1: w+j; mode 2: all ones except worker 0 / job 7 costs 127
    function automatic logic [6:0] cost_fn(input logic [1:0] m, input logic [2:0] w, input logic [2:0] j);
        return m == 2'd0 ? 7'd5 : m == 2'd1 ? 7'(w) + 7'(j) : (w == 3'd0 && j == 3'd7) ? 7'd127 : 7'd1;
    endfunction
    always_comb cost0 = cost_fn(mode, w0, j0);
    always_comb cost1 = cost_fn(mode, w1, j1);

    function automatic logic rdy(input bit s);
        return s ? if1.perm_ready : if0.perm_ready;
    endfunction
    function automatic logic vld(input bit s);
        return s ? v1 : v0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic pulse_start(input bit s);
        if (s) start1 = 1'b1;
        else start0 = 1'b1;
        @(negedge CLK);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // returns at the negedge of the first FETCH cycle
    task automatic send(input bit s, input logic [23:0] p, input logic last);
        int n = 0;
        perm_d = p;
        last_d = last;
        valid_d = 1'b1;
        while (!rdy(s) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) chk("send_timeout", n, 0);
        @(negedge CLK);
        valid_d = 1'b0;
    endtask

    // cycle index (first FETCH = 1) at which ready or Valid rises
    task automatic wait_cyc(input bit s, input bit on_valid, output int n);
        n = 1;
        while (!(on_valid ? vld(s) : rdy(s)) && n < 50) begin
            @(negedge CLK);
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, acc, prev, cyc;
        logic seen;
        repeat (3) @(negedge CLK);
        chk("rst_W", w0, 0);
        chk("rst_J", j0, 0);
        chk("rst_ready", if0.perm_ready, 0);
        chk("rst_mc", mc0, 0);
        chk("rst_min", min0, 1023);
        chk("rst_valid", v0, 0);
        RST = 1'b0;
        @(negedge CLK);

        mode = 2'd0;
        pulse_start(0);
        send(0, ID, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("fetch_W", w0, i);
            chk("fetch_J", j0, i);
            @(negedge CLK);
        end
        chk("cmp_no_valid", v0, 0);
        chk("cmp_hold_J", j0, 7);
        @(negedge CLK);
        chk("single_valid", v0, 1);
        chk("single_min", min0, 40);
        chk("single_mc", mc0, 1);
        @(negedge CLK);
        chk("valid_one_cycle", v0, 0);
        chk("idle_ready", if0.perm_ready, 0);

        mode = 2'd1;
        pulse_start(0);
        send(0, ID, 1'b0);
        send(0, REV, 1'b0);
        pulse_start(0);
        send(0, MIX, 1'b1);
        wait_cyc(0, 1'b1, n);
        chk("tie_valid", v0, 1);
        chk("tie_min", min0, 56);
        chk("tie_mc", mc0, 3);
        @(negedge CLK);

        mode = 2'd0;
        pulse_start(0);
        for (int i = 0; i < 20; i++) send(0, ID, i == 19);
        wait_cyc(0, 1'b1, n);
        chk("sat_valid", v0, 1);
        chk("sat_mc", mc0, 15);
        chk("sat_min", min0, 40);
        @(negedge CLK);

        mode = 2'd2;
        for (int s = 0; s < 2; s++) begin
            pulse_start(s[0]);
            send(s[0], ID, 1'b0);
            wait_cyc(s[0], 1'b0, n);
            chk(s ? "np_full_lat" : "pr_full_lat", n, 10);
            send(s[0], SW, 1'b0);
            wait_cyc(s[0], 1'b0, n);
            chk(s ? "np_ready_lat" : "pr_ready_lat", n, s ? 10 : 3);
            send(s[0], SW, 1'b1);
            wait_cyc(s[0], 1'b1, n);
            chk(s ? "np_valid_lat" : "pr_valid_lat", n, s ? 10 : 3);
            chk(s ? "np_min" : "pr_min", s ? min1 : min0, 8);
            chk(s ? "np_mc" : "pr_mc", s ? mc1 : mc0, 1);
            @(negedge CLK);
        end

        mode = 2'd1;
        pulse_start(0);
        valid_d = 1'b1;
        acc = 0;
        prev = -1;
        cyc = 0;
        while (acc < 3 && cyc < 200) begin
            perm_d = if0.perm_ready ? ID : BAD;
            last_d = acc == 2;
            if (if0.perm_ready) begin
                if (prev >= 0) chk("bp_gap", cyc - prev, 10);
                prev = cyc;
                acc++;
            end
            @(negedge CLK);
            cyc++;
        end
        valid_d = 1'b0;
        chk("bp_accepts", acc, 3);
        wait_cyc(0, 1'b1, n);
        chk("bp_valid_lat", n, 10);
        chk("bp_min", min0, 56);
        chk("bp_mc", mc0, 3);
        @(negedge CLK);

        mode = 2'd0;
        pulse_start(0);
        send(0, ID, 1'b0);
        wait_cyc(0, 1'b0, n);
        send(0, ID, 1'b0);
        repeat (4) @(negedge CLK);
        chk("mid_W", w0, 4);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("mr_min", min0, 1023);
        chk("mr_mc", mc0, 0);
        chk("mr_valid", v0, 0);
        chk("mr_ready", if0.perm_ready, 0);
        chk("mr_W", w0, 0);
        seen = 1'b0;
        repeat (12) begin
            seen = seen | v0;
            @(negedge CLK);
        end
        chk("mr_no_valid", seen, 0);
        pulse_start(0);
        send(0, ID, 1'b1);
        wait_cyc(0, 1'b1, n);
        chk("mr_rerun_lat", n, 10);
        chk("mr_rerun_min", min0, 40);
        chk("mr_rerun_mc", mc0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
